// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, writeback-source IDs and a sizing helper for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int REG_DATA_W = 32;
  localparam int WB_N_SRC   = 3;

  typedef enum logic [2:0] {
    WB_SRC_ALU = 3'd0,
    WB_SRC_LSU = 3'd1,
    WB_SRC_MDU = 3'd2
  } wb_src_e;

  // Pointer width that stays at least one bit wide for degenerate N.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward (wrapping) and grants the first
// requesting source, one-hot, only while en is high.
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N = 3,
  localparam int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found_s;
  logic [PTR_W-1:0] sel_s;

  // Priority scan starting at ptr; found_s blocks every later candidate.
  always_comb begin
    gnt     = '0;
    found_s = 1'b0;
    sel_s   = '0;
    for (int k = 0; k < N; k++) begin
      sel_s = PTR_W'((int'(ptr) + k) % N);
      if (en && !found_s && req[sel_s]) begin
        gnt[sel_s] = 1'b1;
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the single regfile write port among N_SRC writeback sources, with a
// one-entry output register so the write port is driven from flops.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_SRC  = WB_N_SRC,
  parameter int DATA_W = REG_DATA_W,
  parameter int IDX_W  = REG_IDX_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*IDX_W-1:0]  src_index,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  input  logic                    wb_stall,
  output logic                    wreg_en,
  output logic [IDX_W-1:0]        wreg_index,
  output logic [DATA_W-1:0]       wdata,
  output logic                    busy
);

  localparam int PTR_W = ptr_width(N_SRC);

  logic [PTR_W-1:0]  ptr_r;
  logic              out_valid_r;
  logic [IDX_W-1:0]  out_index_r;
  logic [DATA_W-1:0] out_data_r;

  logic              load_s;
  logic              gnt_any_s;
  logic [N_SRC-1:0]  gnt_s;
  logic [PTR_W-1:0]  gnt_idx_s;
  logic [PTR_W-1:0]  ptr_next_s;
  logic [IDX_W-1:0]  gnt_index_s;
  logic [DATA_W-1:0] gnt_data_s;

  // The output register can take a new entry when empty or when its entry drains this cycle.
  assign load_s = ~out_valid_r | ~wb_stall;

  rr_arbiter #(.N(N_SRC)) u_rr (
    .req (src_valid),
    .en  (load_s),
    .ptr (ptr_r),
    .gnt (gnt_s)
  );

  assign src_ready = gnt_s;
  assign gnt_any_s = |gnt_s;

  // One-hot grant selects the winner's number, index and data by AND-OR.
  always_comb begin
    gnt_idx_s   = '0;
    gnt_index_s = '0;
    gnt_data_s  = '0;
    for (int i = 0; i < N_SRC; i++) begin
      gnt_idx_s   = gnt_idx_s   | (gnt_s[i] ? PTR_W'(i) : '0);
      gnt_index_s = gnt_index_s | ({IDX_W{gnt_s[i]}}  & src_index[i*IDX_W +: IDX_W]);
      gnt_data_s  = gnt_data_s  | ({DATA_W{gnt_s[i]}} & src_data[i*DATA_W +: DATA_W]);
    end
    ptr_next_s = (gnt_idx_s == PTR_W'(N_SRC - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
  end

  // Round-robin pointer moves just past the last winner; frozen otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (gnt_any_s) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Output register; a write to index 0 is accepted but dropped by clearing valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_index_r <= '0;
      out_data_r  <= '0;
    end else if (load_s) begin
      out_valid_r <= gnt_any_s & (gnt_index_s != '0);
      if (gnt_any_s) begin
        out_index_r <= gnt_index_s;
        out_data_r  <= gnt_data_s;
      end else begin
        out_index_r <= out_index_r;
        out_data_r  <= out_data_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
      out_index_r <= out_index_r;
      out_data_r  <= out_data_r;
    end
  end

  assign wreg_en    = out_valid_r & ~wb_stall;
  assign wreg_index = out_index_r;
  assign wdata      = out_data_r;
  assign busy       = out_valid_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      src_valid;
  logic [N*IW-1:0]   src_index;
  logic [N*DW-1:0]   src_data;
  logic [N-1:0]      src_ready;
  logic              wb_stall;
  logic              wreg_en;
  logic [IW-1:0]     wreg_index;
  logic [DW-1:0]     wdata;
  logic              busy;

  regfile_wb_arbiter #(.N_SRC(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_index  (src_index),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .wb_stall   (wb_stall),
    .wreg_en    (wreg_en),
    .wreg_index (wreg_index),
    .wdata      (wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending output entry and the priority pointer.
  int          m_ptr;
  bit          m_ov;
  bit [IW-1:0] m_idx;
  bit [DW-1:0] m_data;

  // Requester-side state: what each source is currently offering.
  bit          s_v    [N];
  bit [IW-1:0] s_idx  [N];
  bit [DW-1:0] s_data [N];

  logic [N-1:0]  last_ready;
  logic          last_wen;
  logic          last_busy;
  logic [IW-1:0] last_widx;
  logic [DW-1:0] last_wdata;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_valid[i]             = s_v[i];
      src_index[i*IW +: IW]    = s_idx[i];
      src_data[i*DW +: DW]     = s_data[i];
    end
  endtask

  // One clock: drive at negedge, check combinational view, advance model, wait next negedge.
  task automatic cycle();
    int           g;
    bit           load;
    logic [N-1:0] exp_ready;
    drive();
    #1;
    last_ready = src_ready;
    last_wen   = wreg_en;
    last_busy  = busy;
    last_widx  = wreg_index;
    last_wdata = wdata;
    load = !m_ov || !wb_stall;
    g = -1;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && s_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_val("src_ready",  64'(src_ready),  64'(exp_ready));
    check_val("wreg_en",    64'(wreg_en),    64'(m_ov && !wb_stall));
    check_val("busy",       64'(busy),       64'(m_ov));
    check_val("wreg_index", 64'(wreg_index), 64'(m_idx));
    check_val("wdata",      64'(wdata),      64'(m_data));
    if (load) begin
      if (g >= 0) begin
        m_ov   = (s_idx[g] != 0);
        m_idx  = s_idx[g];
        m_data = s_data[g];
        m_ptr  = (g + 1) % N;
        s_v[g] = 1'b0;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Asserts reset away from the clock edge; unacknowledged requests are cancelled.
  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) s_v[i] = 1'b0;
    drive();
    #1;
    check_val("rst_wreg_en",    64'(wreg_en),    64'(0));
    check_val("rst_busy",       64'(busy),       64'(0));
    check_val("rst_src_ready",  64'(src_ready),  64'(0));
    check_val("rst_wreg_index", 64'(wreg_index), 64'(0));
    check_val("rst_wdata",      64'(wdata),      64'(0));
    m_ptr = 0; m_ov = 1'b0; m_idx = '0; m_data = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic offer(input int i, input int idx, input logic [DW-1:0] d);
    s_v[i]    = 1'b1;
    s_idx[i]  = IW'(idx);
    s_data[i] = d;
  endtask

  initial begin
    reset = 1'b0; wb_stall = 1'b0;
    src_valid = '0; src_index = '0; src_data = '0;
    for (int i = 0; i < N; i++) begin s_v[i] = 1'b0; s_idx[i] = '0; s_data[i] = '0; end
    do_reset();

    // Single source on the LSU slot.
    offer(int'(WB_SRC_LSU), 7, 32'hDEAD_BEEF);
    cycle();
    check_val("single_ready", 64'(last_ready), 64'(3'b010));
    cycle();
    check_val("single_wen",  64'(last_wen),   64'(1));
    check_val("single_idx",  64'(last_widx),  64'(7));
    check_val("single_data", 64'(last_wdata), 64'(32'hDEAD_BEEF));

    // Round robin from reset.
    do_reset();
    offer(0, 1, 32'd10); offer(1, 2, 32'd20); offer(2, 3, 32'd30);
    cycle(); check_val("rr_g0", 64'(last_ready), 64'(3'b001));
    cycle(); check_val("rr_g1", 64'(last_ready), 64'(3'b010));
    check_val("rr_w1", 64'(last_wdata), 64'(32'd10));
    cycle(); check_val("rr_g2", 64'(last_ready), 64'(3'b100));
    check_val("rr_w2", 64'(last_wdata), 64'(32'd20));
    cycle(); check_val("rr_w3", 64'(last_wdata), 64'(32'd30));
    check_val("rr_w3_en", 64'(last_wen), 64'(1));

    // Stall holds the entry and blocks grants.
    do_reset();
    offer(0, 3, 32'd1);
    cycle();
    wb_stall = 1'b1;
    offer(1, 4, 32'd2);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check_val("stall_wen",   64'(last_wen),   64'(0));
      check_val("stall_ready", 64'(last_ready), 64'(0));
      check_val("stall_busy",  64'(last_busy),  64'(1));
    end
    wb_stall = 1'b0;
    cycle();
    check_val("unstall_wen",   64'(last_wen),   64'(1));
    check_val("unstall_idx",   64'(last_widx),  64'(3));
    check_val("unstall_ready", 64'(last_ready), 64'(3'b010));
    cycle();

    // Index 0 is accepted but never written.
    do_reset();
    offer(0, 0, 32'hFFFF_FFFF);
    cycle(); check_val("zero_ready", 64'(last_ready), 64'(3'b001));
    offer(0, 6, 32'd6); offer(1, 6, 32'd7); offer(2, 6, 32'd8);
    cycle();
    check_val("zero_wen",  64'(last_wen),   64'(0));
    check_val("zero_busy", 64'(last_busy),  64'(0));
    check_val("zero_ptr",  64'(last_ready), 64'(3'b010));
    cycle(); cycle(); cycle();

    // Same-index requests serialize in RR order.
    do_reset();
    offer(0, 9, 32'd1); offer(1, 9, 32'd2);
    cycle(); cycle();
    check_val("same_w1", 64'(last_wdata), 64'(1));
    check_val("same_e1", 64'(last_wen),   64'(1));
    cycle();
    check_val("same_w2", 64'(last_wdata), 64'(2));
    check_val("same_e2", 64'(last_wen),   64'(1));

    // Reset during a stall discards the pending write.
    do_reset();
    offer(0, 5, 32'h55);
    cycle();
    wb_stall = 1'b1;
    cycle();
    do_reset();
    wb_stall = 1'b0;
    cycle();
    check_val("rst_stall_nowrite", 64'(last_wen), 64'(0));
    offer(0, 1, 32'd1); offer(1, 2, 32'd2); offer(2, 3, 32'd3);
    cycle();
    check_val("rst_stall_ptr", 64'(last_ready), 64'(3'b001));

    // Randomized traffic with collisions, zero indices, stalls and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_v[i] && ($urandom_range(0, 2) == 0)) begin
          offer(i, int'($urandom_range(0, 7)), DW'($urandom));
        end
      end
      wb_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
